// File: rtl/game_pkg.sv
// Shared constants and helpers for the arcade game input front end.
// Key index constants describe the bit order within one player's switch group.
package game_pkg;

  localparam int NUM_PLAYERS_DEFAULT     = 2;
  localparam int KEYS_PER_PLAYER_DEFAULT = 4;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One switch: 2-flop synchroniser, debouncer, press/release pulse generator.
// Optional hold-to-repeat press pulses when GAME_INPUT_AUTOREPEAT_EN is defined.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CW       = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

`ifdef GAME_INPUT_AUTOREPEAT_EN
  localparam int             RW         = clog2(REPEAT_DELAY) + 1;
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept   = 1'b1;
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d   = accept & sync2_q;
    release_d = accept & ~sync2_q;
`ifdef GAME_INPUT_AUTOREPEAT_EN
    // Any accept while held is a release, so repeats never coincide with it.
    rpt_d = rpt_q;
    if (!stable_q || accept) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      rpt_d   = RPT_RELOAD;
      press_d = 1'b1;
    end else begin
      rpt_d = rpt_q + RW'(1);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
`ifdef GAME_INPUT_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
`ifdef GAME_INPUT_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign stable_o  = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/game_input_frontend.sv
// Pixel clock enable divider plus conditioned player switches on one system clock.
// Build option GAME_INPUT_AUTOREPEAT_EN adds hold-to-repeat press pulses.
module game_input_frontend
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS     = NUM_PLAYERS_DEFAULT,
  parameter int KEYS_PER_PLAYER = KEYS_PER_PLAYER_DEFAULT,
  parameter int CLK_DIV         = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  localparam int NK             = NUM_PLAYERS * KEYS_PER_PLAYER
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [NK-1:0] keys_raw,
  output logic          pix_ce,
  output logic [NK-1:0] keys_stable,
  output logic [NK-1:0] keys_press,
  output logic [NK-1:0] keys_release
);

  localparam int             DW       = clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q, pix_ce_d;

  always_comb begin
    pix_ce_d = (div_q == DIV_LAST);
    div_d    = pix_ce_d ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
    end
  end

  assign pix_ce = pix_ce_q;

  for (genvar i = 0; i < NK; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .key_i    (keys_raw[i]),
      .stable_o (keys_stable[i]),
      .press_o  (keys_press[i]),
      .release_o(keys_release[i])
    );
  end

endmodule

// File: tb/tb_game_input_frontend.sv
// Directed bench: two front ends (CLK_DIV=3 and CLK_DIV=1) sharing clock, reset and switches.
module tb_game_input_frontend;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keys_raw;
  logic       pix3, pix1;
  logic [7:0] st, pr, rl;
  logic [7:0] st1, pr1, rl1;

  int         nvec  = 0;
  int         nfail = 0;
  int         e     = 0;
  bit         in_reset;
  logic [7:0] acc_pr, acc_rl, both;
  logic [7:0] rpt_exp;

  always #5 clk = ~clk;

  game_input_frontend #(
    .NUM_PLAYERS(2), .KEYS_PER_PLAYER(4), .CLK_DIV(3), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .keys_raw(keys_raw), .pix_ce(pix3),
    .keys_stable(st), .keys_press(pr), .keys_release(rl)
  );

  game_input_frontend #(
    .NUM_PLAYERS(2), .KEYS_PER_PLAYER(4), .CLK_DIV(1), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .keys_raw(keys_raw), .pix_ce(pix1),
    .keys_stable(st1), .keys_press(pr1), .keys_release(rl1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // One clock edge, sample 1 time unit later; divider pattern checked on every edge.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    acc_pr |= pr;
    acc_rl |= rl;
    both   |= pr & rl;
    chk("pix_ce_div3", {7'd0, pix3}, in_reset ? 8'h00 : ((e % 3 == 0) ? 8'h01 : 8'h00));
    chk("pix_ce_div1", {7'd0, pix1}, in_reset ? 8'h00 : 8'h01);
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic [7:0] p,
                         input logic [7:0] r);
    chk({tag, "_stable"}, st, s);
    chk({tag, "_press"}, pr, p);
    chk({tag, "_release"}, rl, r);
  endtask

  initial begin
`ifdef GAME_INPUT_AUTOREPEAT_EN
    rpt_exp = 8'h81;
`else
    rpt_exp = 8'h00;
`endif
    reset_n  = 1'b0;
    in_reset = 1'b1;
    keys_raw = 8'h00;
    acc_pr   = '0;
    acc_rl   = '0;
    both     = '0;

    // Reset held while switches toggle: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      keys_raw = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      chk_out("in_reset", 8'h00, 8'h00, 8'h00);
      chk("in_reset_stable_div1", st1, 8'h00);
    end

    keys_raw = 8'hFF;
    reset_n  = 1'b1;
    in_reset = 1'b0;
    e        = 0;
    run_to(5);  chk_out("rst_e5", 8'h00, 8'h00, 8'h00);
    run_to(6);  chk_out("rst_e6", 8'hFF, 8'hFF, 8'h00);
    run_to(7);  chk_out("rst_e7", 8'hFF, 8'h00, 8'h00);

    keys_raw = 8'h00;
    run_to(12); chk_out("all_rel_e12", 8'hFF, 8'h00, 8'h00);
    run_to(13); chk_out("all_rel_e13", 8'h00, 8'h00, 8'hFF);
    run_to(14); chk_out("all_rel_e14", 8'h00, 8'h00, 8'h00);

    // Clean press/release of bit 2.
    keys_raw = 8'h04;
    run_to(19); chk_out("b2_e19", 8'h00, 8'h00, 8'h00);
    run_to(20); chk_out("b2_press", 8'h04, 8'h04, 8'h00);
    run_to(21); chk_out("b2_e21", 8'h04, 8'h00, 8'h00);
    keys_raw = 8'h00;
    run_to(26); chk_out("b2_e26", 8'h04, 8'h00, 8'h00);
    run_to(27); chk_out("b2_release", 8'h00, 8'h00, 8'h04);
    run_to(28); chk_out("b2_e28", 8'h00, 8'h00, 8'h00);

    // Bit 5 glitch of 3 cycles is ignored.
    acc_pr = '0; acc_rl = '0;
    keys_raw = 8'h20;
    run_to(31);
    keys_raw = 8'h00;
    run_to(40);
    chk("glitch_stable", st, 8'h00);
    chk("glitch_no_press", acc_pr, 8'h00);
    chk("glitch_no_release", acc_rl, 8'h00);

    // Bit 5 high for exactly 4 cycles is accepted.
    keys_raw = 8'h20;
    run_to(44);
    keys_raw = 8'h00;
    run_to(45); chk_out("b5_e45", 8'h00, 8'h00, 8'h00);
    run_to(46); chk_out("b5_press", 8'h20, 8'h20, 8'h00);
    run_to(49); chk_out("b5_e49", 8'h20, 8'h00, 8'h00);
    run_to(50); chk_out("b5_release", 8'h00, 8'h00, 8'h20);

    // Two bits pressed together, then held for repeats.
    run_to(51);
    keys_raw = 8'h81;
    run_to(56); chk_out("dual_e56", 8'h00, 8'h00, 8'h00);
    run_to(57); chk_out("dual_press", 8'h81, 8'h81, 8'h00);
    acc_pr = '0;
    run_to(72); chk("hold_quiet", acc_pr, 8'h00);
    run_to(73); chk_out("rpt1", 8'h81, rpt_exp, 8'h00);
    run_to(74); chk_out("rpt1_after", 8'h81, 8'h00, 8'h00);
    run_to(80); chk_out("rpt2_before", 8'h81, 8'h00, 8'h00);
    run_to(81); chk_out("rpt2", 8'h81, rpt_exp, 8'h00);
    run_to(89); chk_out("rpt3", 8'h81, rpt_exp, 8'h00);
    run_to(91);
    keys_raw = 8'h00;
    // Release accept lands on the edge a fourth repeat would have used.
    run_to(96); chk_out("hold_e96", 8'h81, 8'h00, 8'h00);
    run_to(97); chk_out("dual_release", 8'h00, 8'h00, 8'h81);
    acc_pr = '0; acc_rl = '0;
    run_to(110);
    chk("post_rel_no_press", acc_pr, 8'h00);
    chk("post_rel_no_release", acc_rl, 8'h00);

    // Reset two cycles into a debounce of bit 1.
    keys_raw = 8'h02;
    run_to(114); chk_out("mid_e114", 8'h00, 8'h00, 8'h00);
    reset_n  = 1'b0;
    in_reset = 1'b1;
    #2;
    chk_out("mid_in_reset", 8'h00, 8'h00, 8'h00);
    chk("mid_in_reset_pix", {7'd0, pix3}, 8'h00);
    reset_n  = 1'b1;
    in_reset = 1'b0;
    e        = 0;
    run_to(5);  chk_out("mid_e5", 8'h00, 8'h00, 8'h00);
    run_to(6);  chk_out("mid_e6", 8'h02, 8'h02, 8'h00);
    run_to(7);  chk_out("mid_e7", 8'h02, 8'h00, 8'h00);

    chk("press_release_exclusive", both, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
